// File: rtl/eth_axis_tx_framer.sv
// Purpose : frames a uDMA byte stream into one AXI-stream Ethernet TX frame of a programmed length;
//           a source stall or software abort closes the frame with tuser=1 so the MAC drops it.
// Latency : 1 cycle from source transfer to tx_axis_tdata; full throughput of 1 byte/cycle.
// Backpr. : src_ready only when the single output register is free (!tvalid || tready);
//           output beats are held stable while tvalid && !tready.
// Ports   : clk/rst_n (sync, active-low); cfg_len_i/cfg_start_i/cfg_abort_i control;
//           busy_o/done_o/err_o status; src_* byte input; tx_axis_* to the MAC.
// Option  : define ETH_TX_FRAMER_STATS_EN to add stat_good_o/stat_bad_o frame counters.
module eth_axis_tx_framer #(
  parameter int LEN_WIDTH     = 11,
  parameter int TIMEOUT       = 1024,
  parameter int TIMEOUT_WIDTH = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [LEN_WIDTH-1:0] cfg_len_i,
  input  logic                 cfg_start_i,
  input  logic                 cfg_abort_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  input  logic [7:0]           src_data_i,
  input  logic                 src_valid_i,
  output logic                 src_ready_o,
  output logic [7:0]           tx_axis_tdata,
  output logic                 tx_axis_tvalid,
  input  logic                 tx_axis_tready,
  output logic                 tx_axis_tlast,
  output logic                 tx_axis_tuser
`ifdef ETH_TX_FRAMER_STATS_EN
  ,
  output logic [15:0]          stat_good_o,
  output logic [15:0]          stat_bad_o
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, ABORT} state_t;

  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_CNT = TIMEOUT_WIDTH'(TIMEOUT);

  state_t                   state;
  logic [LEN_WIDTH-1:0]     rem;
  logic [LEN_WIDTH-1:0]     rem_after;
  logic [TIMEOUT_WIDTH-1:0] stall;
  logic                     out_free;
  logic                     out_acc;
  logic                     rem_nz;
  logic                     src_xfer;
  logic                     timeout_hit;

  assign out_free    = !tx_axis_tvalid || tx_axis_tready;
  assign out_acc     = tx_axis_tvalid && tx_axis_tready;
  assign rem_nz      = (rem != '0);
  assign timeout_hit = (TIMEOUT != 0) && (stall == TIMEOUT_CNT);
  // Refuse bytes on the timeout cycle so no accepted byte is lost when we jump to ABORT.
  assign src_ready_o = (state == RUN) && out_free && rem_nz && !timeout_hit;
  assign src_xfer    = src_valid_i && src_ready_o;
  // Remaining count after this cycle: an abort that coincides with the last byte is ignored.
  assign rem_after   = src_xfer ? (rem - LEN_WIDTH'(1)) : rem;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      rem            <= '0;
      stall          <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      err_o          <= 1'b0;
      tx_axis_tdata  <= 8'h00;
      tx_axis_tvalid <= 1'b0;
      tx_axis_tlast  <= 1'b0;
      tx_axis_tuser  <= 1'b0;
`ifdef ETH_TX_FRAMER_STATS_EN
      stat_good_o    <= 16'h0000;
      stat_bad_o     <= 16'h0000;
`endif
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_start_i) begin
            if (cfg_len_i != '0) begin
              rem    <= cfg_len_i;
              stall  <= '0;
              busy_o <= 1'b1;
              state  <= RUN;
            end else begin
              err_o <= 1'b1;
            end
          end
        end

        RUN: begin
          if (src_xfer) begin
            tx_axis_tdata  <= src_data_i;
            tx_axis_tvalid <= 1'b1;
            tx_axis_tlast  <= (rem == LEN_WIDTH'(1));
            tx_axis_tuser  <= 1'b0;
            rem            <= rem_after;
          end else if (out_acc) begin
            tx_axis_tvalid <= 1'b0;
            tx_axis_tlast  <= 1'b0;
          end

          // Only a missing source byte counts as a stall; MAC backpressure does not.
          if (src_xfer) begin
            stall <= '0;
          end else if (rem_nz && out_free && !src_valid_i) begin
            stall <= stall + TIMEOUT_WIDTH'(1);
          end

          if (out_acc && tx_axis_tlast) begin
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= IDLE;
`ifdef ETH_TX_FRAMER_STATS_EN
            stat_good_o <= stat_good_o + 16'd1;
`endif
          end else if (timeout_hit || (cfg_abort_i && rem_after != '0)) begin
            state <= ABORT;
          end
        end

        ABORT: begin
          // tuser marks the terminator; any pending data beat has tuser=0 and drains first.
          if (tx_axis_tvalid && tx_axis_tuser) begin
            if (tx_axis_tready) begin
              tx_axis_tvalid <= 1'b0;
              tx_axis_tlast  <= 1'b0;
              tx_axis_tuser  <= 1'b0;
              err_o          <= 1'b1;
              busy_o         <= 1'b0;
              state          <= IDLE;
`ifdef ETH_TX_FRAMER_STATS_EN
              stat_bad_o <= stat_bad_o + 16'd1;
`endif
            end
          end else if (out_free) begin
            tx_axis_tdata  <= 8'h00;
            tx_axis_tvalid <= 1'b1;
            tx_axis_tlast  <= 1'b1;
            tx_axis_tuser  <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_axis_tx_framer.sv
// Testbench for eth_axis_tx_framer: a directed vector table plus hand-written
// sequences for long frames, MAC backpressure, source timeout and mid-frame reset.
module tb_eth_axis_tx_framer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] cfg_len;
  logic        cfg_start, cfg_abort;
  logic        busy, done, err;
  logic [7:0]  src_data;
  logic        src_valid, src_ready;
  logic [7:0]  tdata;
  logic        tvalid, tready, tlast, tuser;
`ifdef ETH_TX_FRAMER_STATS_EN
  logic [15:0] stat_good, stat_bad;
`endif

  int applied = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  eth_axis_tx_framer #(.LEN_WIDTH(11), .TIMEOUT(16), .TIMEOUT_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_len_i(cfg_len), .cfg_start_i(cfg_start), .cfg_abort_i(cfg_abort),
    .busy_o(busy), .done_o(done), .err_o(err),
    .src_data_i(src_data), .src_valid_i(src_valid), .src_ready_o(src_ready),
    .tx_axis_tdata(tdata), .tx_axis_tvalid(tvalid), .tx_axis_tready(tready),
    .tx_axis_tlast(tlast), .tx_axis_tuser(tuser)
`ifdef ETH_TX_FRAMER_STATS_EN
    , .stat_good_o(stat_good), .stat_bad_o(stat_bad)
`endif
  );

  typedef struct {
    logic        start;
    logic [10:0] len;
    logic        abort;
    logic        sv;
    logic [7:0]  sd;
    logic        tr;
    logic        e_srdy;
    logic        e_tvalid;
    logic [7:0]  e_tdata;
    logic        e_tlast;
    logic        e_tuser;
    logic        e_busy;
    logic        e_done;
    logic        e_err;
  } vec_t;

  vec_t vt[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Runs a clean frame with an always-valid source and tready=1; byte k carries base+k.
  task automatic run_frame(input int len, input logic [7:0] base, input string nm);
    @(negedge clk);
    cfg_start = 1'b1; cfg_len = 11'(len); src_valid = 1'b1; src_data = base; tready = 1'b1;
    @(posedge clk); #1;
    chk({nm, " busy after start"}, {30'd0, busy, tvalid}, 32'h2);
    @(negedge clk);
    cfg_start = 1'b0;
    for (int k = 0; k < len; k++) begin
      if (k != 0) @(negedge clk);
      src_data = base + 8'(k);
      @(posedge clk); #1;
      chk($sformatf("%s beat%0d", nm, k + 1), {20'd0, tvalid, tdata, tlast, tuser},
          {20'd0, 1'b1, base + 8'(k), (k == len - 1), 1'b0});
    end
    @(negedge clk);
    src_valid = 1'b0;
    @(posedge clk); #1;
    chk({nm, " done/busy/tvalid"}, {29'd0, done, busy, tvalid}, 32'h4);
  endtask

  initial begin
    logic [7:0] got[$];
    logic [7:0] nb, pd;
    logic       xs, held, seen_done, found;
    int         n;

    //             st  len    ab  sv  sd     tr | srdy tv  td     tl  tu  bsy dn  er
    vt[0]  = '{1'b1, 11'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[1]  = '{1'b0, 11'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 11'd3, 1'b0, 1'b1, 8'hA1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 11'd7, 1'b0, 1'b1, 8'hA1, 1'b1, 1'b1, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 11'd0, 1'b0, 1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 11'd0, 1'b0, 1'b1, 8'hA2, 1'b1, 1'b1, 1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 11'd0, 1'b1, 1'b1, 8'hA3, 1'b1, 1'b1, 1'b1, 8'hA3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 11'd0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hA3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 11'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[9]  = '{1'b0, 11'd0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[10] = '{1'b1, 11'd4, 1'b0, 1'b1, 8'hB1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[11] = '{1'b0, 11'd0, 1'b0, 1'b1, 8'hB1, 1'b0, 1'b1, 1'b1, 8'hB1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[12] = '{1'b0, 11'd0, 1'b1, 1'b1, 8'hB2, 1'b0, 1'b0, 1'b1, 8'hB1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[13] = '{1'b0, 11'd0, 1'b0, 1'b1, 8'hB2, 1'b0, 1'b0, 1'b1, 8'hB1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[14] = '{1'b0, 11'd0, 1'b0, 1'b1, 8'hB2, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[15] = '{1'b0, 11'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[16] = '{1'b0, 11'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[17] = '{1'b0, 11'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; cfg_len = '0; cfg_start = 1'b0; cfg_abort = 1'b0;
    src_data = 8'h00; src_valid = 1'b0; tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", {24'd0, tvalid, tlast, tuser, busy, done, err, src_ready, 1'b0}, 32'h0);
    chk("reset tdata", {24'd0, tdata}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: zero-length start, start while busy, abort on last byte, abort with pending beat.
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      cfg_start = vt[i].start; cfg_len = vt[i].len; cfg_abort = vt[i].abort;
      src_valid = vt[i].sv; src_data = vt[i].sd; tready = vt[i].tr;
      #1;
      chk($sformatf("vec%0d src_ready", i), {31'd0, src_ready}, {31'd0, vt[i].e_srdy});
      @(posedge clk); #1;
      chk($sformatf("vec%0d ctl", i), {26'd0, tvalid, tlast, tuser, busy, done, err},
          {26'd0, vt[i].e_tvalid, vt[i].e_tlast, vt[i].e_tuser, vt[i].e_busy, vt[i].e_done, vt[i].e_err});
      if (vt[i].e_tvalid) chk($sformatf("vec%0d tdata", i), {24'd0, tdata}, {24'd0, vt[i].e_tdata});
    end
    @(negedge clk);
    cfg_start = 1'b0; cfg_abort = 1'b0; src_valid = 1'b0; tready = 1'b1;

    // 64-byte frame at full rate.
    run_frame(64, 8'h01, "len64");

    // 5-byte frame with tready toggling every cycle.
    @(negedge clk);
    cfg_start = 1'b1; cfg_len = 11'd5;
    @(posedge clk);
    @(negedge clk);
    cfg_start = 1'b0;
    nb = 8'd1; seen_done = 1'b0;
    for (int c = 0; c < 40 && !seen_done; c++) begin
      if (c != 0) @(negedge clk);
      tready = c[0];
      src_valid = (nb <= 8'd5);
      src_data = nb;
      #1;
      xs = src_valid && src_ready;
      if (tvalid && tready) got.push_back(tdata);
      held = tvalid && !tready;
      pd = tdata;
      @(posedge clk); #1;
      if (xs) nb = nb + 8'd1;
      if (held) chk($sformatf("toggle stable c%0d", c), {24'd0, tdata}, {24'd0, pd});
      if (done) seen_done = 1'b1;
    end
    chk("toggle done seen", {31'd0, seen_done}, 32'd1);
    chk("toggle beat count", got.size(), 32'd5);
    for (int i = 0; i < got.size(); i++)
      chk($sformatf("toggle byte%0d", i + 1), {24'd0, got[i]}, i + 1);
    @(negedge clk);
    src_valid = 1'b0; tready = 1'b1;

    // Source stalls after 3 of 10 bytes; TIMEOUT=16.
    @(negedge clk);
    cfg_start = 1'b1; cfg_len = 11'd10; src_valid = 1'b1; src_data = 8'h10;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      cfg_start = 1'b0; src_data = 8'h10 + 8'(k);
      @(posedge clk);
    end
    @(negedge clk);
    src_valid = 1'b0;
    n = 0; found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); #1;
      n++;
      if (tvalid && tuser) found = 1'b1;
    end
    chk("timeout terminator seen", {31'd0, found}, 32'd1);
    chk("timeout cycles to terminator", n, 32'd18);
    chk("terminator beat", {23'd0, tdata, tlast, tuser}, {23'd0, 8'h00, 1'b1, 1'b1});
    @(posedge clk); #1;
    chk("timeout err", {28'd0, err, done, busy, tvalid}, 32'h8);
`ifdef ETH_TX_FRAMER_STATS_EN
    chk("stat_good", {16'd0, stat_good}, 32'd3);
    chk("stat_bad", {16'd0, stat_bad}, 32'd2);
`endif

    // Reset with 30 bytes still owed, then a clean 8-byte frame.
    @(negedge clk);
    cfg_start = 1'b1; cfg_len = 11'd40; src_valid = 1'b1; tready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cfg_start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0; src_valid = 1'b0;
    @(posedge clk); #1;
    chk("midreset tvalid/busy", {30'd0, tvalid, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(8, 8'h80, "post-reset");
`ifdef ETH_TX_FRAMER_STATS_EN
    chk("stat_good after reset", {16'd0, stat_good}, 32'd1);
    chk("stat_bad after reset", {16'd0, stat_bad}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
